// File: rtl/msdap_pkg.sv
// rtl/msdap_pkg.sv - shared MSDAP output-stage constants and state encoding
package msdap_pkg;

  // Default output word width of the filter datapath
  localparam int WIDTH = 40;

  // Index of the most significant bit of a w-bit word
  function automatic int msb_idx(input int w);
    return w - 1;
  endfunction

  // Bit that carries the frame strobe (first bit on the pins)
  localparam int FRAME_BIT = msb_idx(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_reg.sv
// rtl/piso_reg.sv - parallel-load shift-left register, MSB presented on msb_o
module piso_reg #(
  parameter int WIDTH = msdap_pkg::WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;

  // Clear beats load beats shift; zeros enter at the LSB end
  always_ff @(negedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= din_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/sdo_serializer.sv
// rtl/sdo_serializer.sv - dual-channel MSB-first serializer with one-deep holding buffer
module sdo_serializer #(
  parameter int WIDTH = msdap_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_l,
  input  logic [WIDTH-1:0] in_r,
  output logic             in_ready,
  output logic             sdo_l,
  output logic             sdo_r,
  output logic             frame,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_ovf
);

  import msdap_pkg::*;

  localparam int TOP_BIT = msb_idx(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOP_BIT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic [WIDTH-1:0] hold_r_q, hold_r_d;
  logic             hold_full_q, hold_full_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;

  logic             sr_load, sr_shift, sr_clear;
  logic [WIDTH-1:0] sr_din_l, sr_din_r;

  // Next-state decode: word start, bit shifting, hold buffer and drop detection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    frame_d     = 1'b0;
    busy_d      = busy_q;
    ovf_set     = 1'b0;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_clear    = 1'b0;
    sr_din_l    = in_l;
    sr_din_r    = in_r;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_load = 1'b1;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
          frame_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          // Bit 0 has had its full cycle on the pins: chain or stop
          if (hold_full_q) begin
            sr_load  = 1'b1;
            sr_din_l = hold_l_q;
            sr_din_r = hold_r_q;
            cnt_d    = CNT_LAST;
            frame_d  = 1'b1;
            if (in_valid) begin
              // Buffer empties into the shifter this edge, so the new word fits
              hold_l_d = in_l;
              hold_r_d = in_r;
            end else begin
              hold_full_d = 1'b0;
            end
          end else if (in_valid) begin
            sr_load = 1'b1;
            cnt_d   = CNT_LAST;
            frame_d = 1'b1;
          end else begin
            sr_clear = 1'b1;
            state_d  = IDLE;
            busy_d   = 1'b0;
          end
        end else begin
          sr_shift = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (in_valid) begin
            if (!hold_full_q) begin
              hold_l_d    = in_l;
              hold_r_d    = in_r;
              hold_full_d = 1'b1;
            end else begin
              ovf_set = 1'b1;
            end
          end
        end
      end
    endcase

    // A drop on the same edge as a clear request must stay visible
    ovf_d = ovf_set | (ovf_q & ~clr_ovf);
  end

  // Control state and registered status outputs
  always_ff @(negedge sclk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  piso_reg #(.WIDTH(WIDTH)) u_sr_l (
    .clk_i     (sclk),
    .reset_n_i (reset_n),
    .clear_i   (sr_clear),
    .load_i    (sr_load),
    .shift_i   (sr_shift),
    .din_i     (sr_din_l),
    .msb_o     (sdo_l)
  );

  piso_reg #(.WIDTH(WIDTH)) u_sr_r (
    .clk_i     (sclk),
    .reset_n_i (reset_n),
    .clear_i   (sr_clear),
    .load_i    (sr_load),
    .shift_i   (sr_shift),
    .din_i     (sr_din_r),
    .msb_o     (sdo_r)
  );

  assign in_ready = ~hold_full_q;
  assign frame    = frame_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sdo_serializer.sv
// tb/tb_sdo_serializer.sv - self-checking bench for sdo_serializer
module tb_sdo_serializer;

  localparam int W = 40;

  logic         sclk;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] in_l;
  logic [W-1:0] in_r;
  logic         in_ready;
  logic         sdo_l;
  logic         sdo_r;
  logic         frame;
  logic         busy;
  logic         overflow;
  logic         clr_ovf;

  sdo_serializer #(.WIDTH(W), .CNT_W(6)) dut (
    .sclk     (sclk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_l     (in_l),
    .in_r     (in_r),
    .in_ready (in_ready),
    .sdo_l    (sdo_l),
    .sdo_r    (sdo_r),
    .frame    (frame),
    .busy     (busy),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial sclk = 1'b1;
  always #5 sclk = ~sclk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int tcyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tcyc);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference model: a word in flight plus a list of waiting words
  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } word_t;

  word_t  pend[$];
  word_t  cur;
  bit     m_active;
  int     m_pos;
  bit     m_frame;
  bit     m_ovf;

  task model_step();
    word_t nw;
    bit    dropped;
    nw.l = in_l;
    nw.r = in_r;
    dropped = 1'b0;
    if (!reset_n) begin
      pend.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_frame  = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      if (m_active && m_pos > 0) begin
        m_pos--;
        m_frame = 1'b0;
        if (in_valid) begin
          if (pend.size() == 0) pend.push_back(nw);
          else dropped = 1'b1;
        end
      end else if (m_active && pend.size() > 0) begin
        cur     = pend.pop_front();
        m_pos   = W - 1;
        m_frame = 1'b1;
        if (in_valid) pend.push_back(nw);
      end else if (in_valid) begin
        cur      = nw;
        m_pos    = W - 1;
        m_active = 1'b1;
        m_frame  = 1'b1;
      end else begin
        m_active = 1'b0;
        m_frame  = 1'b0;
      end
      m_ovf = dropped | (m_ovf & ~clr_ovf);
    end
  endtask

  task cycle();
    @(negedge sclk);
    model_step();
    tcyc++;
    @(posedge sclk);
    chk("sdo_l",    64'(sdo_l),    64'(m_active ? cur.l[m_pos] : 1'b0));
    chk("sdo_r",    64'(sdo_r),    64'(m_active ? cur.r[m_pos] : 1'b0));
    chk("frame",    64'(frame),    64'(m_frame));
    chk("busy",     64'(busy),     64'(m_active));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("in_ready", 64'(in_ready), 64'(pend.size() == 0));
  endtask

  task idle(input int n);
    repeat (n) cycle();
  endtask

  task post(input logic [W-1:0] l, input logic [W-1:0] r);
    in_valid = 1'b1;
    in_l = l;
    in_r = r;
    cycle();
    in_valid = 1'b0;
  endtask

  task run_until(input int t);
    int guard;
    guard = 0;
    while (tcyc < t && guard < 1000) begin
      cycle();
      guard++;
    end
  endtask

  typedef struct {
    int   cyc;
    logic sl;
    logic sr;
    logic fr;
    logic bz;
    logic rdy;
  } vec_t;

  vec_t tbl[6];

  logic [W-1:0] wa_l, wa_r, wb_l, wb_r, wc_l, wc_r;
  int mark;
  int dens;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_l     = '0;
    in_r     = '0;
    clr_ovf  = 1'b0;

    tbl[0] = '{0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{38, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{39, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    idle(2);
    chk("rst_sdo_l", 64'(sdo_l), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Single word against the hand-derived table
    post(40'h80_0000_0001, 40'h7F_FFFF_FFFE);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) cycle();
      for (int i = 0; i < 6; i++) begin
        if (tbl[i].cyc == k) begin
          chk("tbl_sdo_l", 64'(sdo_l), 64'(tbl[i].sl));
          chk("tbl_sdo_r", 64'(sdo_r), 64'(tbl[i].sr));
          chk("tbl_frame", 64'(frame), 64'(tbl[i].fr));
          chk("tbl_busy", 64'(busy), 64'(tbl[i].bz));
          chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].rdy));
        end
      end
    end
    idle(3);

    // Back-to-back: B posted 10 cycles into A
    wa_l = 40'hA5_5A5A_A5A5; wa_r = 40'h12_3456_789B;
    wb_l = 40'h7E_0000_FFFF; wb_r = 40'h81_FFFF_0000;
    post(wa_l, wa_r);
    mark = tcyc;
    idle(9);
    post(wb_l, wb_r);
    chk("b2b_in_ready_low", 64'(in_ready), 64'd0);
    run_until(mark + 39);
    chk("b2b_a_lsb", 64'(sdo_l), 64'(wa_l[0]));
    cycle();
    chk("b2b_b_frame", 64'(frame), 64'd1);
    chk("b2b_b_msb_l", 64'(sdo_l), 64'(wb_l[W-1]));
    chk("b2b_b_msb_r", 64'(sdo_r), 64'(wb_r[W-1]));
    chk("b2b_in_ready_high", 64'(in_ready), 64'd1);
    idle(45);

    // Overflow: B at cycle 5, C at cycle 8 is dropped
    wc_l = 40'hFF_FFFF_FFFF; wc_r = 40'hFF_FFFF_FFFF;
    post(wa_l, wa_r);
    mark = tcyc;
    idle(4);
    post(wb_l, wb_r);
    idle(2);
    post(wc_l, wc_r);
    chk("ovf_set", 64'(overflow), 64'd1);
    run_until(mark + 40);
    chk("ovf_b_frame", 64'(frame), 64'd1);
    chk("ovf_b_msb", 64'(sdo_l), 64'(wb_l[W-1]));
    run_until(mark + 80);
    chk("ovf_c_not_sent", 64'(busy), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);
    idle(3);

    // Collision with hold full at A's last-bit edge
    post(wa_l, wa_r);
    mark = tcyc;
    idle(9);
    post(wb_l, wb_r);
    run_until(mark + 39);
    post(wc_l, wc_r);
    chk("col_b_frame", 64'(frame), 64'd1);
    chk("col_b_msb", 64'(sdo_l), 64'(wb_l[W-1]));
    chk("col_hold_full", 64'(in_ready), 64'd0);
    chk("col_no_ovf", 64'(overflow), 64'd0);
    run_until(mark + 80);
    chk("col_c_frame", 64'(frame), 64'd1);
    chk("col_c_msb", 64'(sdo_l), 64'(wc_l[W-1]));
    idle(45);

    // Collision with hold empty: direct reload
    post(wa_l, wa_r);
    mark = tcyc;
    run_until(mark + 39);
    post(wb_l, wb_r);
    chk("col2_frame", 64'(frame), 64'd1);
    chk("col2_msb", 64'(sdo_r), 64'(wb_r[W-1]));
    chk("col2_in_ready", 64'(in_ready), 64'd1);
    idle(45);

    // Reset mid-word with a word waiting in the hold buffer
    post(wa_l, wa_r);
    mark = tcyc;
    idle(9);
    post(wb_l, wb_r);
    run_until(mark + 19);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_sdo", 64'({sdo_l, sdo_r, frame}), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    idle(45);
    chk("mid_rst_hold_gone", 64'(busy), 64'd0);
    post(wc_l, 40'h00_0000_0001);
    chk("mid_rst_new_frame", 64'(frame), 64'd1);
    chk("mid_rst_new_msb", 64'({sdo_l, sdo_r}), 64'b10);
    idle(45);

    // Randomized traffic, alternating sparse and dense posting
    for (int i = 0; i < 4000; i++) begin
      dens = ((i / 500) % 2 == 1) ? 3 : 30;
      in_valid = ($urandom_range(0, dens - 1) == 0);
      in_l = W'({$urandom(), $urandom()});
      in_r = W'({$urandom(), $urandom()});
      clr_ovf = ($urandom_range(0, 39) == 0);
      reset_n = !($urandom_range(0, 599) == 0);
      cycle();
    end
    in_valid = 1'b0;
    clr_ovf  = 1'b0;
    reset_n  = 1'b1;
    idle(45);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sdo_serializer.md
Name: sdo_serializer

Overview:
- Output end of the MSDAP datapath. Takes the 40-bit left/right filter results produced by the shift-accumulators and transmits them MSB-first on two serial data pins, with a frame strobe on the first bit.
- Has a one-deep holding buffer, so the next result can be posted while the current word is still shifting out.
- Detects and flags a dropped word (overflow).

Parameters:
- WIDTH, 40, bits per output word (must be >= 2).
- CNT_W, 6, bit-counter width (must satisfy 2^CNT_W >= WIDTH).

Ports:
- sclk  input  1  system clock; every flop updates on the falling edge.
- reset_n  input  1  synchronous active-low reset, sampled on falling edge of sclk.
- in_valid  input  1  one-cycle strobe: in_l/in_r hold a new result.
- in_l  input  WIDTH  left-channel result (two's complement).
- in_r  input  WIDTH  right-channel result (two's complement).
- in_ready  output  1  high when the holding buffer is empty.
- sdo_l  output  1  left serial data, MSB first.
- sdo_r  output  1  right serial data, MSB first.
- frame  output  1  high during bit WIDTH-1 (first bit) of each word.
- busy  output  1  high while a word is being shifted.
- overflow  output  1  sticky: a word was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (reset_n=0 at a falling edge):
  - Outputs: sdo_l=0, sdo_r=0, frame=0, busy=0, overflow=0, in_ready=1.
  - Internals: shift registers, holding buffer and counter go to 0; state goes to IDLE.
  - Reset mid-word aborts the transmission and discards the holding buffer.
- All outputs are registered except in_ready, which is the combinational inverse of hold_full.
- State IDLE:
  - in_valid=1: load in_l/in_r directly into the shift registers, counter=WIDTH-1, go to SHIFT.
  - On that same edge: frame=1, busy=1, sdo_l/sdo_r = bit WIDTH-1 of the loaded words. Latency from the in_valid edge to the MSB on the pins is 0 edges.
- State SHIFT:
  - Each edge shifts both registers left by one; sdo = the new MSB; counter decrements; frame=0.
  - When an edge is taken with counter==0, the last bit (bit 0) has been on the pins for one cycle. Then:
    - hold_full=1: transfer the holding buffer to the shift registers, counter=WIDTH-1, frame=1, stay in SHIFT. Back-to-back words have no gap.
    - hold_full=0 and in_valid=1: load the inputs directly, same as the row above.
    - else: go to IDLE with sdo_l=0, sdo_r=0, busy=0, frame=0.
- in_valid while in SHIFT, not at the last-bit edge:
  - hold_full=0: capture into the holding buffer; hold_full=1.
  - hold_full=1: drop the new word, set overflow; the holding buffer keeps its old word.
- in_valid at the last-bit edge with hold_full=1: the holding word moves to the shift registers and the new word goes into the holding buffer. No overflow.
- overflow is sticky. clr_ovf=1 clears it. If a set and clr_ovf occur on the same edge, the set wins.
- A word occupies exactly WIDTH cycles on the pins. Both channels are always bit-aligned.
- No arithmetic: bits are passed through unmodified, sign bit first.

Decomposition:
- Shared package msdap_pkg holds:
  - the WIDTH default (40);
  - the IDLE/SHIFT state encoding constants;
  - the FRAME_BIT index constant (WIDTH-1).
- One natural sub-module, piso_reg: a WIDTH-bit parallel-load shift-left register with load/shift/clear. Instantiate it twice (left and right); the FSM, counter, holding buffer and overflow logic live in the top.

Test Plan:
- Reset then single word: in_l=40'h80_0000_0001, in_r=40'h7F_FFFF_FFFE, pulse in_valid.
  - Expect frame=1 on the first cycle only; sdo_l = 1, then 38 zeros, then 1; sdo_r is the bitwise complement.
  - busy drops 40 cycles after the load; the pins return to 0.
- Back-to-back: post word A, then word B 10 cycles later.
  - in_ready goes low after B is posted.
  - B's MSB appears on the cycle right after A's LSB, with frame=1 and no idle gap.
  - in_ready returns high at B's load.
- Overflow: post A, then B at cycle 5 and C at cycle 8.
  - overflow=1 from cycle 8; C is never transmitted; B is sent after A.
  - A clr_ovf pulse then returns overflow to 0.
- Last-bit collision: hold_full=1 and in_valid asserted exactly at A's last-bit edge.
  - B is transmitted next and C goes to the holding buffer; overflow stays 0.
  - A second collision case: hold empty with in_valid at the last-bit edge. Expect a direct back-to-back load.
- Reset mid-word: assert reset_n=0 at bit 20 of word A for one edge.
  - All outputs go to reset values on that edge; hold is cleared.
  - A new word posted afterwards transmits cleanly with frame=1.
